// File: rtl/enable_table_writer.sv
// Byte-stream writer for the 2-bit {cs_ram,cs_bus} enable table: SYNC, CFG, data bytes
// unpacked 4 entries each. Define ENTABLE_CHECKSUM_EN to add the trailing XOR checksum byte.
module enable_table_writer #(
  parameter int CONFIG_BITS = 5,
  parameter int ADDR_ENTRY_BITS = 8,
  parameter logic [7:0] SYNC_BYTE = 8'hE7,
  localparam int IDX_BITS = ADDR_ENTRY_BITS + 1,
  localparam int WA = CONFIG_BITS + 1 + ADDR_ENTRY_BITS
) (
  input  logic          fpga_clk,
  input  logic          rst_n,
  input  logic [7:0]    in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          wr_en,
  output logic [WA-1:0] wr_addr,
  output logic [1:0]    wr_data,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [1:0]    err_code
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CFG    = 3'd1,
    S_DATA   = 3'd2,
    S_UNPACK = 3'd3,
    S_CSUM   = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  localparam logic [IDX_BITS-1:0] IDX_LAST = '1;

`ifdef ENTABLE_CHECKSUM_EN
  localparam state_t S_FIN = S_CSUM;
`else
  localparam state_t S_FIN = S_DONE;
`endif

  state_t                 state_r;
  state_t                 state_n;
  logic [CONFIG_BITS-1:0] cfg_r;
  logic [IDX_BITS-1:0]    idx_r;
  logic [7:0]             byte_r;
  logic                   err_r;
  logic [1:0]             err_code_r;
  logic                   cfg_bad_s;
`ifdef ENTABLE_CHECKSUM_EN
  logic [7:0]             csum_r;
`endif

  assign cfg_bad_s = (in_data >> CONFIG_BITS) != 8'd0;

  // State register
  always_ff @(posedge fpga_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // Next-state logic; DONE also listens for SYNC so a back-to-back frame is not lost
  always_comb begin
    state_n = state_r;
    case (state_r)
      S_IDLE, S_DONE: begin
        if (in_valid && in_data == SYNC_BYTE) state_n = S_CFG;
        else                                  state_n = S_IDLE;
      end
      S_CFG: begin
        if (in_valid) state_n = cfg_bad_s ? S_IDLE : S_DATA;
        else          state_n = S_CFG;
      end
      S_DATA: begin
        if (in_valid) state_n = S_UNPACK;
        else          state_n = S_DATA;
      end
      S_UNPACK: begin
        if (idx_r[1:0] == 2'd3) state_n = (idx_r == IDX_LAST) ? S_FIN : S_DATA;
        else                    state_n = S_UNPACK;
      end
`ifdef ENTABLE_CHECKSUM_EN
      S_CSUM: begin
        if (in_valid) state_n = (in_data == csum_r) ? S_DONE : S_IDLE;
        else          state_n = S_CSUM;
      end
`endif
      default: state_n = S_IDLE;
    endcase
  end

  // Datapath: config latch, entry index, byte buffer, checksum and error pulse
  always_ff @(posedge fpga_clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_r      <= '0;
      idx_r      <= '0;
      byte_r     <= 8'd0;
      err_r      <= 1'b0;
      err_code_r <= 2'b00;
`ifdef ENTABLE_CHECKSUM_EN
      csum_r     <= 8'd0;
`endif
    end else begin
      err_r <= 1'b0;
      case (state_r)
        S_CFG: begin
          if (in_valid && cfg_bad_s) begin
            err_r      <= 1'b1;
            err_code_r <= 2'b01;
          end else if (in_valid) begin
            cfg_r  <= in_data[CONFIG_BITS-1:0];
            idx_r  <= '0;
`ifdef ENTABLE_CHECKSUM_EN
            csum_r <= 8'd0;
`endif
          end
        end
        S_DATA: begin
          if (in_valid) begin
            byte_r <= in_data;
`ifdef ENTABLE_CHECKSUM_EN
            csum_r <= csum_r ^ in_data;
`endif
          end
        end
        S_UNPACK: idx_r <= idx_r + 1'b1;
`ifdef ENTABLE_CHECKSUM_EN
        S_CSUM: begin
          if (in_valid && in_data != csum_r) begin
            err_r      <= 1'b1;
            err_code_r <= 2'b10;
          end
        end
`endif
        default: err_r <= 1'b0;
      endcase
    end
  end

  // Outputs decoded from registered state only
  always_comb begin
    in_ready = (state_r == S_IDLE) || (state_r == S_CFG) || (state_r == S_DATA) ||
               (state_r == S_CSUM) || (state_r == S_DONE);
    wr_en    = (state_r == S_UNPACK);
    busy     = (state_r == S_CFG) || (state_r == S_DATA) || (state_r == S_UNPACK) ||
               (state_r == S_CSUM);
    done     = (state_r == S_DONE);
    err      = err_r;
    err_code = err_code_r;
    wr_addr  = {cfg_r, idx_r};
    case (idx_r[1:0])
      2'd0:    wr_data = byte_r[1:0];
      2'd1:    wr_data = byte_r[3:2];
      2'd2:    wr_data = byte_r[5:4];
      2'd3:    wr_data = byte_r[7:6];
      default: wr_data = 2'b00;
    endcase
  end

endmodule

// File: tb/tb_enable_table_writer.sv
// Self-checking bench for enable_table_writer: vector table, frame-level write model,
// random in_valid throttling and mid-frame reset.
module tb_enable_table_writer;

  logic        fpga_clk;
  logic        rst_n;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        wr_en;
  logic [13:0] wr_addr;
  logic [1:0]  wr_data;
  logic        busy;
  logic        done;
  logic        err;
  logic [1:0]  err_code;

  enable_table_writer dut (
    .fpga_clk(fpga_clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .err(err), .err_code(err_code)
  );

  initial fpga_clk = 1'b0;
  always #5 fpga_clk = ~fpga_clk;

  typedef struct {
    logic [7:0] d;
    logic       v;
    logic       rdy;
    logic       bsy;
    logic       er;
    logic [1:0] ec;
    logic       we;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int n_done;
  int n_err;
  int low_left = 0;
  bit want_high = 1'b0;
  logic [7:0]  dat[128];
  logic [7:0]  frame_q[$];
  logic [15:0] exp_q[$];
  logic [15:0] got_q[$];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h expected %0h", nm, act, exp);
    end
  endtask

  // One clock: drive inputs, sample at the falling edge, return whether the byte was taken
  task automatic cycle(input logic [7:0] d, input logic v, output logic acc);
    in_data = d;
    in_valid = v;
    @(negedge fpga_clk);
    acc = v && in_ready;
    if (wr_en) got_q.push_back({wr_addr, wr_data});
    if (done) n_done++;
    if (err) n_err++;
    if (done || err) chk("done_err_exclusive", int'(done & err), 0);
    if (low_left > 0) begin
      chk("unpack_ready_low", int'({in_ready, wr_en}), 1);
      low_left--;
      if (low_left == 0) want_high = 1'b1;
    end else if (want_high) begin
      chk("ready_after_4", int'(in_ready), 1);
      want_high = 1'b0;
    end
    @(posedge fpga_clk);
    #1;
  endtask

  // Reference: frame bytes plus the ordered list of {addr, data} writes they imply
  task automatic make_frame(input logic [4:0] cfg, input bit bad_csum);
    logic [7:0] x;
    x = 8'd0;
    frame_q = {};
    exp_q = {};
    frame_q.push_back(8'hE7);
    frame_q.push_back({3'b000, cfg});
    for (int k = 0; k < 128; k++) begin
      frame_q.push_back(dat[k]);
      x ^= dat[k];
      for (int j = 0; j < 4; j++)
        exp_q.push_back({cfg, 9'(k * 4 + j), 2'((dat[k] >> (2 * j)) & 8'd3)});
    end
`ifdef ENTABLE_CHECKSUM_EN
    frame_q.push_back(bad_csum ? ~x : x);
`else
    if (bad_csum) x = 8'd0;
`endif
  endtask

  task automatic send(input int n_bytes, input bit rnd);
    for (int i = 0; i < n_bytes; i++) begin
      logic acc;
      int guard;
      acc = 1'b0;
      guard = 0;
      while (!acc && guard < 40) begin
        cycle(frame_q[i], rnd ? 1'($urandom_range(0, 1)) : 1'b1, acc);
        guard++;
      end
      if (!acc) chk("accept_timeout", i, -1);
      if (acc && i >= 2 && i < 130) low_left = 4;
    end
  endtask

  task automatic run_frame(input string tag, input logic [4:0] cfg, input bit bad_csum,
                           input bit rnd);
    int mism;
    logic a;
    make_frame(cfg, bad_csum);
    got_q = {};
    n_done = 0;
    n_err = 0;
    send(frame_q.size(), rnd);
    for (int c = 0; c < 10; c++) cycle(8'h00, 1'b0, a);
    chk({tag, " nwrites"}, got_q.size(), exp_q.size());
    mism = 0;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      if (got_q[i] !== exp_q[i]) mism++;
    chk({tag, " write_seq"}, mism, 0);
    if (bad_csum) begin
      chk({tag, " done_cnt"}, n_done, 0);
      chk({tag, " err_cnt"}, n_err, 1);
      chk({tag, " err_code"}, int'(err_code), 2);
    end else begin
      chk({tag, " done_cnt"}, n_done, 1);
      chk({tag, " err_cnt"}, n_err, 0);
    end
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst_n = 1'b0;
    low_left = 0;
    want_high = 1'b0;
    @(negedge fpga_clk);
    rst_n = 1'b1;
    @(posedge fpga_clk);
    #1;
  endtask

  initial begin
    vec_t vt[11];
    logic a;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_data = 8'h00;
    #12;
    chk("rst in_ready", int'(in_ready), 1);
    chk("rst wr_en", int'(wr_en), 0);
    chk("rst wr_addr", int'(wr_addr), 0);
    chk("rst wr_data", int'(wr_data), 0);
    chk("rst busy", int'(busy), 0);
    chk("rst done", int'(done), 0);
    chk("rst err", int'(err), 0);
    chk("rst err_code", int'(err_code), 0);
    @(negedge fpga_clk);
    rst_n = 1'b1;
    @(posedge fpga_clk);
    #1;

    // Garbage, bad CFG, recovery, in_valid stall in DATA, first unpack cycle
    vt[0]  = '{8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0};
    vt[1]  = '{8'hFF, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0};
    vt[2]  = '{8'h12, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0};
    vt[3]  = '{8'hE7, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0};
    vt[4]  = '{8'h25, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0};
    vt[5]  = '{8'hE7, 1'b1, 1'b1, 1'b0, 1'b1, 2'b01, 1'b0};
    vt[6]  = '{8'h03, 1'b1, 1'b1, 1'b1, 1'b0, 2'b01, 1'b0};
    vt[7]  = '{8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 2'b01, 1'b0};
    vt[8]  = '{8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 2'b01, 1'b0};
    vt[9]  = '{8'h5A, 1'b1, 1'b1, 1'b1, 1'b0, 2'b01, 1'b0};
    vt[10] = '{8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 1'b1};
    for (int i = 0; i < 11; i++) begin
      in_data = vt[i].d;
      in_valid = vt[i].v;
      @(negedge fpga_clk);
      chk($sformatf("vec%0d in_ready", i), int'(in_ready), int'(vt[i].rdy));
      chk($sformatf("vec%0d busy", i), int'(busy), int'(vt[i].bsy));
      chk($sformatf("vec%0d err", i), int'(err), int'(vt[i].er));
      chk($sformatf("vec%0d err_code", i), int'(err_code), int'(vt[i].ec));
      chk($sformatf("vec%0d wr_en", i), int'(wr_en), int'(vt[i].we));
      @(posedge fpga_clk);
      #1;
    end
    do_reset();

    // Test 1: cfg 3, all E4 -> 0x0600..0x07FF, data 0,1,2,3 repeating
    for (int k = 0; k < 128; k++) dat[k] = 8'hE4;
    run_frame("t1", 5'h03, 1'b0, 1'b0);
    if (got_q.size() > 0) chk("t1 first_addr", int'(got_q[0][15:2]), 16'h0600);

    // Test 2: garbage then cfg 1F with random data
    cycle(8'h00, 1'b1, a);
    cycle(8'hFF, 1'b1, a);
    cycle(8'h12, 1'b1, a);
    for (int k = 0; k < 128; k++) dat[k] = 8'($urandom);
    run_frame("t2", 5'h1F, 1'b0, 1'b0);
    if (got_q.size() > 0) chk("t2 last_addr", int'(got_q[got_q.size()-1][15:2]), 16'h3FFF);

`ifdef ENTABLE_CHECKSUM_EN
    // Test 4: wrong checksum -> all writes made, then err_code 10, no done
    run_frame("t4", 5'h0A, 1'b1, 1'b0);
`endif

    // Test 6: same frame as test 1 with in_valid randomly throttled
    for (int k = 0; k < 128; k++) dat[k] = 8'hE4;
    run_frame("t6", 5'h03, 1'b0, 1'b1);

    // Test 5: async reset during the unpack of data byte 37
    for (int k = 0; k < 128; k++) dat[k] = 8'($urandom);
    make_frame(5'h07, 1'b0);
    got_q = {};
    send(39, 1'b0);
    chk("t5 wr_en_before_rst", int'(wr_en), 1);
    rst_n = 1'b0;
    #1;
    chk("t5 wr_en_in_rst", int'(wr_en), 0);
    chk("t5 ready_in_rst", int'(in_ready), 1);
    chk("t5 busy_in_rst", int'(busy), 0);
    chk("t5 writes_before_rst", got_q.size(), 36 * 4);
    low_left = 0;
    want_high = 1'b0;
    @(negedge fpga_clk);
    rst_n = 1'b1;
    @(posedge fpga_clk);
    #1;
    run_frame("t5 fresh", 5'h07, 1'b0, 1'b0);

    // Random frames with random config and throttling
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 128; k++) dat[k] = 8'($urandom);
      run_frame($sformatf("rnd%0d", r), 5'($urandom), 1'b0, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
